// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D main-memory arbiter: FSM states, grant sources and
// the starvation counter helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_I  = 2'd1,
        ARB_BUSY_D  = 2'd2,
        ARB_RECOVER = 2'd3
    } arb_state_e;

    // Bit positions in the request/grant vectors
    localparam int GNT_I  = 0;  // I-side line read
    localparam int GNT_DR = 1;  // D-side line read (miss fill)
    localparam int GNT_DW = 2;  // D-side line write-back
    localparam int GNT_N  = 3;

    typedef logic [GNT_N-1:0] gnt_vec_t;

    localparam int CNT_W = 4;

    // Saturating increment of the starvation counter
    function automatic logic [CNT_W-1:0] starve_inc(input logic [CNT_W-1:0] cnt,
                                                    input logic [CNT_W-1:0] limit);
        return (cnt >= limit) ? limit : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arbiter_prio_sel.sv
// Combinational priority selector: a starved I side beats everything, otherwise
// D read > I read > D write. Output is one-hot (or zero when nothing requests).
module arb_prio_sel
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  gnt_vec_t               req,
    input  logic [CNT_W-1:0]       starve_cnt,
    output gnt_vec_t               gnt
);

    logic starved;
    assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Fixed priority chain with the starvation override at the top
    always_comb begin
        gnt = '0;
        if (starved && req[GNT_I])
            gnt[GNT_I] = 1'b1;
        else if (req[GNT_DR])
            gnt[GNT_DR] = 1'b1;
        else if (req[GNT_I])
            gnt[GNT_I] = 1'b1;
        else if (req[GNT_DW])
            gnt[GNT_DW] = 1'b1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory line port between the I-cache and D-cache wrappers.
// One grant at a time, held until mem_ready; all outputs are registered.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 28,
    parameter int DATA_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e       state, state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    gnt_vec_t         req, gnt;
    logic             gnt_d;

    assign req[GNT_I]  = i_mem_read;
    assign req[GNT_DR] = d_mem_read;
    assign req[GNT_DW] = d_mem_write;

    arb_prio_sel #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio_sel (
        .req        (req),
        .starve_cnt (starve_cnt),
        .gnt        (gnt)
    );

    // Grant only counts in IDLE; RECOVER deliberately ignores both sides
    assign gnt_d = gnt[GNT_DR] | gnt[GNT_DW];

    // State register
    always_ff @(posedge clk) begin
        if (proc_reset)
            state <= ARB_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: IDLE -> BUSY_x on grant, BUSY_x -> RECOVER on mem_ready,
    // RECOVER always lasts one cycle while the served side drops its request
    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB_IDLE: begin
                if (gnt[GNT_I])
                    state_nxt = ARB_BUSY_I;
                else if (gnt_d)
                    state_nxt = ARB_BUSY_D;
            end
            ARB_BUSY_I,
            ARB_BUSY_D: begin
                if (mem_ready)
                    state_nxt = ARB_RECOVER;
            end
            ARB_RECOVER: state_nxt = ARB_IDLE;
            default:     state_nxt = ARB_IDLE;
        endcase
    end

    // Registered memory-side request, requester responses and starvation count
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            i_mem_ready <= 1'b0;
            d_mem_ready <= 1'b0;
            i_mem_rdata <= '0;
            d_mem_rdata <= '0;
            starve_cnt  <= '0;
        end else begin
            i_mem_ready <= 1'b0;
            d_mem_ready <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    if (gnt[GNT_I]) begin
                        mem_read   <= 1'b1;
                        mem_addr   <= i_mem_addr;
                        mem_wdata  <= '0;
                        starve_cnt <= '0;
                    end else if (gnt_d) begin
                        mem_read   <= gnt[GNT_DR];
                        mem_write  <= gnt[GNT_DW];
                        mem_addr   <= d_mem_addr;
                        mem_wdata  <= d_mem_wdata;
                        // Only D grants that bypass a waiting I side count
                        starve_cnt <= i_mem_read
                                      ? starve_inc(starve_cnt, CNT_W'(STARVE_LIMIT))
                                      : '0;
                    end
                end
                ARB_BUSY_I: begin
                    if (mem_ready) begin
                        mem_read    <= 1'b0;
                        i_mem_ready <= 1'b1;
                        i_mem_rdata <= mem_rdata;
                    end
                end
                ARB_BUSY_D: begin
                    if (mem_ready) begin
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b0;
                        d_mem_ready <= 1'b1;
                        // Write-backs complete without touching the read data
                        if (mem_read)
                            d_mem_rdata <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
